// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - branch resolution types and stage payload
package br_pkg;

    // Width the stage payload is built for; the top checks its XLEN against it.
    localparam int BR_XLEN = 32;

    typedef enum logic [2:0] {
        BR_NONE   = 3'b000,
        BR_EQ     = 3'b001,
        BR_NE     = 3'b010,
        BR_LT     = 3'b011,
        BR_GE     = 3'b100,
        BR_LTU    = 3'b101,
        BR_GEU    = 3'b110,
        BR_ALWAYS = 3'b111
    } br_type_e;

    typedef struct packed {
        logic                valid;
        br_type_e            br_type;
        logic                taken;
        logic                pred_taken;
        logic [BR_XLEN-1:0]  pc;
        logic [BR_XLEN-1:0]  br_target;
    } br_stage_t;

endpackage

// File: rtl/br_cond_eval.sv
// rtl/br_cond_eval.sv - combinational branch condition evaluation
// Ports:
//   br_type  in  3     condition code (br_type_e encoding)
//   opr_a    in  XLEN  rs1 value
//   opr_b    in  XLEN  rs2 value
//   taken    out 1     condition result
module br_cond_eval
    import br_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      br_type,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (br_type_e'(br_type))
            BR_NONE:   taken = 1'b0;
            BR_EQ:     taken = (opr_a == opr_b);
            BR_NE:     taken = (opr_a != opr_b);
            BR_LT:     taken = ($signed(opr_a) <  $signed(opr_b));
            BR_GE:     taken = ($signed(opr_a) >= $signed(opr_b));
            BR_LTU:    taken = (opr_a <  opr_b);
            BR_GEU:    taken = (opr_a >= opr_b);
            BR_ALWAYS: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/br_resolve_unit.sv
// rtl/br_resolve_unit.sv - pipelined branch resolution with handshakes, flush and counters
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush                        drop every in-flight entry
//   in_valid / in_ready          request handshake
//   br_type, opr_a, opr_b        condition code and operands
//   pred_taken, pc, br_target    prediction, branch PC, branch target
//   out_valid / out_ready        result handshake
//   br_taken, mispredict         resolved direction, direction differs from prediction
//   redirect_pc                  taken ? br_target : pc+4
//   br_count, mispredict_count   saturating retire counters
module br_resolve_unit
    import br_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       br_type,
    input  logic [XLEN-1:0]  opr_a,
    input  logic [XLEN-1:0]  opr_b,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  br_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             br_taken,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispredict_count
);

    if (STAGES < 1 || STAGES > 2) begin : g_bad_stages
        $error("br_resolve_unit: STAGES must be 1 or 2");
    end
    if (XLEN != BR_XLEN) begin : g_bad_xlen
        $error("br_resolve_unit: XLEN must equal br_pkg::BR_XLEN");
    end

    logic                  cond_taken;
    br_stage_t             req;
    // chain[0] is the incoming request, chain[k+1] is the register of stage k.
    br_stage_t [STAGES:0]  chain;
    logic [STAGES-1:0]     stage_valid;
    logic [STAGES-1:0]     adv;
    br_stage_t             last;
    logic                  out_fire;
    logic [CNT_W-1:0]      br_count_d, br_count_q;
    logic [CNT_W-1:0]      mis_count_d, mis_count_q;

    br_cond_eval #(.XLEN(XLEN)) u_cond (
        .br_type (br_type),
        .opr_a   (opr_a),
        .opr_b   (opr_b),
        .taken   (cond_taken)
    );

    // A stage may load when it is empty or the stage after it moves on.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = !stage_valid[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = !stage_valid[k] || adv[k+1];
        end
    end

    assign in_ready = !flush && adv[0];

    always_comb begin
        req            = '0;
        req.valid      = in_valid && in_ready;
        req.br_type    = br_type_e'(br_type);
        req.taken      = cond_taken;
        req.pred_taken = pred_taken;
        req.pc         = pc;
        req.br_target  = br_target;
    end

    assign chain[0] = req;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        br_stage_t stg_d;
        br_stage_t stg_q;

        always_comb begin
            stg_d = stg_q;
            if (flush) begin
                stg_d.valid = 1'b0;
            end else if (adv[k]) begin
                stg_d = chain[k];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stg_q <= '0;
            end else begin
                stg_q <= stg_d;
            end
        end

        assign chain[k+1]     = stg_q;
        assign stage_valid[k] = stg_q.valid;
    end

    assign last = chain[STAGES];

    // Result fields are forced to zero when nothing is presented so the
    // post-reset outputs read as zero.
    assign out_valid   = last.valid;
    assign br_taken    = last.valid && last.taken;
    assign mispredict  = last.valid && (last.taken != last.pred_taken);
    assign redirect_pc = !last.valid ? '0 :
                         last.taken  ? last.br_target : (last.pc + XLEN'(4));

    // Flush wins over a simultaneous output handshake.
    assign out_fire = out_valid && out_ready && !flush;

    always_comb begin
        br_count_d  = br_count_q;
        mis_count_d = mis_count_q;
        if (out_fire) begin
            if (last.br_type != BR_NONE && br_count_q != '1) begin
                br_count_d = br_count_q + CNT_W'(1);
            end
            if (mispredict && mis_count_q != '1) begin
                mis_count_d = mis_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q  <= '0;
            mis_count_q <= '0;
        end else begin
            br_count_q  <= br_count_d;
            mis_count_q <= mis_count_d;
        end
    end

    assign br_count         = br_count_q;
    assign mispredict_count = mis_count_q;

endmodule
